// File: rtl/sram_arb_if.sv
// Purpose: bundles the three sram-like buses around sram_arb (inst, data, mem).
// Latency: pure wiring, adds no latency of its own.
// Backpressure: carried by *_addr_ok; responses (*_data_ok) are never stalled.
//
// Modports:
//   slave  - arbiter view: samples inst_*/data_* requests and mem_* responses,
//            drives inst/data handshakes and the shared mem_* request.
//   master - environment view (core top + AXI bridge side), the mirror image.
interface sram_arb_if;
  // instruction-fetch master
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // load/store master
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // shared memory port
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_arb.sv
// Purpose: 2:1 arbiter of the inst/data sram-like masters onto one memory port,
//          with an in-order owner FIFO that routes each response to its issuer.
// Latency: zero-cycle combinational request path; responses routed combinationally.
// Backpressure: mem_addr_ok stalls the granted master (grant locked until accepted);
//               a full owner FIFO drops mem_req; responses cannot be stalled.
//
// Ports:
//   clk    - core clock
//   resetn - asynchronous active-low reset
//   bus    - sram_arb_if.slave: inst_*, data_* request/response, mem_* shared port
// Parameters:
//   OST_DEPTH - max accepted-but-unanswered transactions (power of two, 2..16)
// Build option:
//   SRAM_ARB_RR_EN - when defined, round-robin select in IDLE; otherwise data
//                    has fixed priority over inst.

// Small generic FIFO used for the owner tags.
// Latency: push visible at the head one cycle later; pop frees space next cycle.
// Backpressure: pushes while full and pops while empty are ignored.
module sram_arb_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop_vld,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_cnt == FULL_CNT);
  assign o_empty    = (r_cnt == '0);
  assign w_push     = i_push_vld & ~o_full;
  assign w_pop      = i_pop_vld & ~o_empty;
  assign o_head_dat = r_mem[r_rptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the count says valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end
endmodule

module sram_arb #(
  parameter int OST_DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetn,
  sram_arb_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_sel_vld;   // selected master has req high
  logic w_sel_d;     // selected master: 0 = inst, 1 = data
  logic w_full;
  logic w_empty;
  logic w_head_d;    // owner of the oldest outstanding transaction
  logic w_mem_req;
  logic w_hs;        // address handshake on the shared port
  logic w_rsp;       // response that belongs to a tracked transaction

`ifdef SRAM_ARB_RR_EN
  logic r_rr_last;   // last granted master: 0 = inst, 1 = data

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   r_rr_last <= 1'b0;
    else if (w_hs) r_rr_last <= w_sel_d;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Select + next state. In HOLD_* the grant is pinned to the holder so a
  // pending request is never abandoned for the other master.
  always_comb begin
    w_sel_vld   = 1'b0;
    w_sel_d     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      HOLD_I: begin
        w_sel_vld = bus.inst_req;
        w_sel_d   = 1'b0;
      end
      HOLD_D: begin
        w_sel_vld = bus.data_req;
        w_sel_d   = 1'b1;
      end
      default: begin
        w_sel_vld = bus.inst_req | bus.data_req;
`ifdef SRAM_ARB_RR_EN
        if (bus.inst_req & bus.data_req) w_sel_d = ~r_rr_last;
        else                             w_sel_d = bus.data_req;
`else
        w_sel_d = bus.data_req;
`endif
      end
    endcase

    case (r_state)
      IDLE: begin
        // Not accepted (busy port or full FIFO): lock onto this master.
        if (w_sel_vld & ~w_hs) w_state_nxt = w_sel_d ? HOLD_D : HOLD_I;
      end
      HOLD_I, HOLD_D: begin
        // Release on acceptance, or if the holder illegally drops req.
        if (w_hs | ~w_sel_vld) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // resetn gating keeps the request quiet while reset is held, even though
  // the masters may already be driving req.
  assign w_mem_req = w_sel_vld & ~w_full & resetn;
  assign w_hs      = w_mem_req & bus.mem_addr_ok;
  assign w_rsp     = bus.mem_data_ok & ~w_empty;

  sram_arb_fifo #(
    .WIDTH (1),
    .DEPTH (OST_DEPTH)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .i_push_vld (w_hs),
    .i_push_dat (w_sel_d),
    .i_pop_vld  (w_rsp),
    .o_head_dat (w_head_d),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_wr    = w_sel_d ? bus.data_wr    : bus.inst_wr;
  assign bus.mem_size  = w_sel_d ? bus.data_size  : bus.inst_size;
  assign bus.mem_wstrb = w_sel_d ? bus.data_wstrb : bus.inst_wstrb;
  assign bus.mem_addr  = w_sel_d ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata = w_sel_d ? bus.data_wdata : bus.inst_wdata;

  assign bus.inst_addr_ok = w_hs & ~w_sel_d;
  assign bus.data_addr_ok = w_hs & w_sel_d;

  // Responses from an empty FIFO are spurious and dropped.
  assign bus.inst_data_ok = w_rsp & ~w_head_d;
  assign bus.data_data_ok = w_rsp & w_head_d;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
endmodule
